// File: rtl/reg_bank16.sv
// Sixteen-entry register bank with a pending-write scoreboard for issue-stage hazard detection.
// All outputs are registered except hazard_a/hazard_b, which decode the registered pending bits.
module reg_bank16 #(
    parameter int unsigned WIDTH   = 32,
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [3:0]            wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  iss_en,
    input  logic [3:0]            iss_addr,
    input  logic                  flush,
    input  logic [3:0]            rd_sel_a,
    input  logic [3:0]            rd_sel_b,
    output logic [16*WIDTH-1:0]   regs_flat,
    output logic [15:0]           pending,
    output logic                  hazard_a,
    output logic                  hazard_b,
    output logic [4:0]            busy_count
);

    localparam int unsigned NREGS = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned CW    = 5;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;
    logic [CW-1:0]    busy_count_q;
    logic [CW-1:0]    busy_count_d;

    logic wr_ok;
    logic iss_ok;

    // r0 is hardwired when ZERO_R0 is set, so its writes and issues are dropped.
    assign wr_ok  = wr_en  && !(ZERO_R0 && (wr_addr  == AW'(0)));
    assign iss_ok = iss_en && !(ZERO_R0 && (iss_addr == AW'(0)));

    // Register file next state.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_ok) begin
            regs_d[wr_addr] = wr_data;
        end
        if (ZERO_R0) begin
            regs_d[0] = '0;
        end
    end

    // Scoreboard: flush or write-back clears first, then issue sets, so a new producer wins.
    always_comb begin
        pending_d = pending_q;
        if (flush) begin
            pending_d = '0;
        end else if (wr_en) begin
            pending_d[wr_addr] = 1'b0;
        end
        if (iss_ok) begin
            pending_d[iss_addr] = 1'b1;
        end
        if (ZERO_R0) begin
            pending_d[0] = 1'b0;
        end
    end

    always_comb begin
        busy_count_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            busy_count_d = busy_count_d + CW'(pending_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            pending_q    <= '0;
            busy_count_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pending_q    <= pending_d;
            busy_count_q <= busy_count_d;
        end
    end

    // The r0 slice is tied off so it reads zero even before the first reset.
    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        if (ZERO_R0 && (g == 0)) begin : g_zero
            assign regs_flat[WIDTH*g +: WIDTH] = '0;
        end else begin : g_reg
            assign regs_flat[WIDTH*g +: WIDTH] = regs_q[g];
        end
    end

    assign pending    = pending_q;
    assign busy_count = busy_count_q;
    assign hazard_a   = pending_q[rd_sel_a];
    assign hazard_b   = pending_q[rd_sel_b];

endmodule

// File: tb/tb_reg_bank16.sv
// Directed and random checks of reg_bank16 against an array-based reference model.
module tb_reg_bank16;

    localparam int unsigned WIDTH = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic                wr_en;
    logic [3:0]          wr_addr;
    logic [WIDTH-1:0]    wr_data;
    logic                iss_en;
    logic [3:0]          iss_addr;
    logic                flush;
    logic [3:0]          rd_sel_a;
    logic [3:0]          rd_sel_b;
    logic [16*WIDTH-1:0] regs_flat;
    logic [15:0]         pending;
    logic                hazard_a;
    logic                hazard_b;
    logic [4:0]          busy_count;

    always #5 clk = ~clk;

    reg_bank16 #(.WIDTH(WIDTH), .ZERO_R0(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .iss_en     (iss_en),
        .iss_addr   (iss_addr),
        .flush      (flush),
        .rd_sel_a   (rd_sel_a),
        .rd_sel_b   (rd_sel_b),
        .regs_flat  (regs_flat),
        .pending    (pending),
        .hazard_a   (hazard_a),
        .hazard_b   (hazard_b),
        .busy_count (busy_count)
    );

    logic [WIDTH-1:0] m_regs [16];
    bit               m_pend [16];
    int n_assert = 0;
    int n_fail   = 0;

    function automatic logic [16*WIDTH-1:0] exp_flat();
        logic [16*WIDTH-1:0] f;
        for (int i = 0; i < 16; i++) f[WIDTH*i +: WIDTH] = m_regs[i];
        return f;
    endfunction

    function automatic logic [15:0] exp_pend();
        logic [15:0] p;
        for (int i = 0; i < 16; i++) p[i] = m_pend[i];
        return p;
    endfunction

    function automatic logic [4:0] exp_busy();
        int n = 0;
        for (int i = 0; i < 16; i++) if (m_pend[i]) n++;
        return 5'(n);
    endfunction

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
    endtask

    // Apply the edge to the model from the inputs currently driven, then clock the DUT.
    task automatic tick();
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (wr_en && wr_addr != 4'd0) m_regs[wr_addr] = wr_data;
            if (flush) begin
                for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
            end else if (wr_en) begin
                m_pend[wr_addr] = 1'b0;
            end
            if (iss_en && iss_addr != 4'd0) m_pend[iss_addr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".regs"}, 512'(regs_flat), 512'(exp_flat()));
        chk({tag, ".pend"}, 512'(pending), 512'(exp_pend()));
        chk({tag, ".busy"}, 512'(busy_count), 512'(exp_busy()));
        chk({tag, ".haz_a"}, 512'(hazard_a), 512'(m_pend[rd_sel_a]));
        chk({tag, ".haz_b"}, 512'(hazard_b), 512'(m_pend[rd_sel_b]));
    endtask

    initial begin
        idle();
        rd_sel_a = '0;
        rd_sel_b = '0;
        for (int i = 0; i < 16; i++) begin
            m_regs[i] = 'x;
            m_pend[i] = 1'b0;
        end
        reset = 1'b1;
        #1;
        chk("r0_before_reset", 512'(regs_flat[31:0]), 512'(0));

        // Reset held two cycles, then write-through to r5
        tick();
        tick();
        chk("reset_regs_zero", 512'(regs_flat), 512'(0));
        check_model("reset");
        idle();
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF;
        #1;
        chk("r5_old_before_edge", 512'(regs_flat[191:160]), 512'(0));
        tick();
        idle();
        chk("r5_written", 512'(regs_flat[191:160]), 512'(32'hDEADBEEF));
        check_model("write5");

        // r0 protection
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h12345678;
        iss_en = 1'b1; iss_addr = 4'd0;
        tick();
        idle();
        chk("r0_value", 512'(regs_flat[31:0]), 512'(0));
        chk("r0_pending", 512'(pending[0]), 512'(0));
        chk("r0_busy", 512'(busy_count), 512'(0));

        // Scoreboard issue / hazard / write-back
        iss_en = 1'b1; iss_addr = 4'd3; rd_sel_a = 4'd3; rd_sel_b = 4'd7;
        #1;
        chk("haz_a_before_edge", 512'(hazard_a), 512'(0));
        tick();
        chk("haz_a_after_edge", 512'(hazard_a), 512'(1));
        iss_addr = 4'd7;
        tick();
        idle();
        chk("sb_pend", 512'(pending), 512'(16'h0088));
        chk("sb_busy", 512'(busy_count), 512'(2));
        chk("sb_haz_a", 512'(hazard_a), 512'(1));
        chk("sb_haz_b", 512'(hazard_b), 512'(1));
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = $urandom;
        tick();
        idle();
        chk("wb_pend", 512'(pending), 512'(16'h0080));
        chk("wb_haz_a", 512'(hazard_a), 512'(0));
        chk("wb_busy", 512'(busy_count), 512'(1));
        check_model("wb");

        // Same-cycle collisions
        iss_en = 1'b1; iss_addr = 4'd4;
        tick();
        iss_en = 1'b1; iss_addr = 4'd4;
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'hA5A50004;
        tick();
        idle();
        chk("coll_pend4", 512'(pending[4]), 512'(1));
        chk("coll_r4", 512'(regs_flat[159:128]), 512'(32'hA5A50004));
        flush = 1'b1; iss_en = 1'b1; iss_addr = 4'd9;
        tick();
        idle();
        chk("flush_iss9", 512'(pending), 512'(16'h0200));
        check_model("flush");

        // Fill r1..r15, then reset mid-operation with a write to r2
        for (int i = 1; i < 16; i++) begin
            iss_en = 1'b1; iss_addr = 4'(i);
            tick();
        end
        idle();
        chk("fill_busy", 512'(busy_count), 512'(15));
        chk("fill_pend", 512'(pending), 512'(16'hFFFE));
        reset = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'hCAFE0002;
        tick();
        idle();
        chk("rst_pend", 512'(pending), 512'(0));
        chk("rst_busy", 512'(busy_count), 512'(0));
        chk("rst_r2", 512'(regs_flat[95:64]), 512'(0));
        check_model("rst_mid");

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            reset    = ($urandom_range(63) == 0);
            flush    = ($urandom_range(15) == 0);
            wr_en    = $urandom_range(1);
            wr_addr  = 4'($urandom_range(15));
            wr_data  = $urandom;
            iss_en   = $urandom_range(1);
            iss_addr = 4'($urandom_range(15));
            rd_sel_a = 4'($urandom_range(15));
            rd_sel_b = 4'($urandom_range(15));
            tick();
            check_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_bank16.md
Name: reg_bank16

Overview:
- Sixteen-entry, 32-bit architectural register bank with an integrated pending-write scoreboard.
- Sits directly upstream of the 16:1 read-select muxes. It drives all sixteen register values as one flat bus; each read mux picks one of them.
- Also flags read hazards on registers that have an issued but not yet written-back result, so the issue stage can stall.

Parameters:
- WIDTH, 32, data width of each register.
- ZERO_R0, 1, when 1: r0 reads constant 0, writes to r0 are ignored, and issues to r0 are ignored.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write-back strobe.
- wr_addr  input  4  write-back destination register.
- wr_data  input  WIDTH  write-back data.
- iss_en  input  1  issue strobe; marks a destination register as pending.
- iss_addr  input  4  destination register of the issued instruction.
- flush  input  1  clears all pending bits (pipeline squash).
- rd_sel_a  input  4  port-A read select (mirrors the port-A mux select).
- rd_sel_b  input  4  port-B read select.
- regs_flat  output  16*WIDTH  register i on bits [WIDTH*i+WIDTH-1 : WIDTH*i]; feeds mux inputs in0..in15.
- pending  output  16  bit i = 1 means register i awaits write-back.
- hazard_a  output  1  pending[rd_sel_a].
- hazard_b  output  1  pending[rd_sel_b].
- busy_count  output  5  number of set pending bits (0..16).

Behaviour:
- Reset (clk edge with reset=1):
  - all registers become 0; pending becomes 0; busy_count becomes 0.
  - Reset overrides wr_en, iss_en and flush in the same cycle.
  - Reset asserted mid-operation discards every in-flight pending mark.
- Write:
  - On a clk edge with wr_en=1, register wr_addr loads wr_data.
  - The new value appears on regs_flat on the cycle after that edge.
  - There is no internal bypass: a same-cycle read through the downstream mux sees the old value.
- Write to r0 with ZERO_R0=1:
  - No state change.
  - regs_flat bits [WIDTH-1:0] are constant 0 at all times, including out of reset.
- Write to a register that is not pending is legal; the register updates.
- Pending bit update at each clk edge, evaluated in this priority order:
  1. If flush=1, clear all bits; otherwise, if wr_en=1, clear bit wr_addr.
  2. Then, if iss_en=1, set bit iss_addr.
  - Net effect: issue wins over both flush and write-back to the same register. A register that is issued and written back in the same cycle stays pending, because the new producer supersedes the old one.
- iss_en to r0 with ZERO_R0=1: ignored; pending[0] is always 0.
- Re-issuing a register that is already pending keeps the bit at 1; there is no count per register.
- hazard_a and hazard_b:
  - purely combinational from the registered pending bits and the rd_sel inputs, with no latency.
  - A bit set at edge N is visible from the cycle after edge N.
- busy_count:
  - registered; equals the popcount of pending after each edge.
  - Range 0..16 (0..15 when ZERO_R0=1). It never wraps.
- All outputs come from registers except hazard_a and hazard_b.

Test Plan:
1. Reset, then write-through:
   - Stimulus: hold reset 2 cycles, then wr_en=1, wr_addr=5, wr_data=0xDEADBEEF.
   - Required: regs_flat all zero after reset; the next cycle regs_flat[191:160]=0xDEADBEEF and every other slice is unchanged.
2. r0 protection (ZERO_R0=1):
   - Stimulus: write 0x12345678 to r0, and issue r0.
   - Required: regs_flat[31:0]=0, pending[0]=0, busy_count=0.
3. Scoreboard:
   - Stimulus: issue r3, then r7; then rd_sel_a=3, rd_sel_b=7; then write-back r3.
   - Required: pending=0x0088 and busy_count=2; hazard_a=1 and hazard_b=1; after the write-back edge, pending=0x0080, hazard_a=0, busy_count=1.
4. Same-cycle collisions:
   - Stimulus: with r4 pending, assert iss_en and wr_en together, both targeting register 4.
   - Required: pending[4] stays 1 and register r4 takes wr_data.
   - Stimulus: flush=1 together with iss_addr=9.
   - Required: pending=0x0200.
5. Fill and reset mid-operation:
   - Stimulus: issue r1..r15 on consecutive cycles.
   - Required: busy_count reaches 15 and pending=0xFFFE.
   - Stimulus: assert reset on the next cycle, together with wr_en to r2.
   - Required: pending=0, busy_count=0, r2=0.
